// File: rtl/semi_cmd_conditioner_pkg.sv
// ---------------------------------------------------------------------------
// semi_cmd_conditioner_pkg
// Shared definitions for the semi-auto driving input stage:
//   - button bit positions inside the 4-bit button / command vectors
//   - command FSM state encoding
//   - small helpers for counter sizing and one-hot detection
// ---------------------------------------------------------------------------
package semi_cmd_conditioner_pkg;

   // Button / command bit positions: {left, right, straight, back}
   localparam int BTN_L = 3;
   localparam int BTN_R = 2;
   localparam int BTN_S = 1;
   localparam int BTN_B = 0;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      HOLD    = 2'b01,
      RELEASE = 2'b10
   } cmd_state_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Bits needed to count 0..n-1; never less than one bit.
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // True when exactly one bit of v is set.
   function automatic logic is_single(input logic [3:0] v);
      return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
   endfunction

endpackage

// File: rtl/semi_cmd_conditioner_debounce_bit.sv
// ---------------------------------------------------------------------------
// debounce_bit
// Two-flop synchroniser followed by a tick-based persistence filter. The
// filtered level only follows the synchronised input once a differing level
// has been seen on N consecutive debounce ticks; any return to the current
// level clears the count.
// Ports:
//   sys_clk  in   system clock
//   rst      in   asynchronous reset, active-low
//   tick     in   one-cycle debounce tick from the prescaler
//   din      in   raw asynchronous input bit
//   dout     out  debounced, accepted level
// ---------------------------------------------------------------------------
module debounce_bit
   import semi_cmd_conditioner_pkg::*;
#(
   parameter int N  = 3,
   parameter int CW = cnt_width(N)
) (
   input  logic sys_clk,
   input  logic rst,
   input  logic tick,
   input  logic din,
   output logic dout
);

   localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

   logic          sync1_reg;
   logic          sync2_reg;
   logic          stable_reg;
   logic [CW-1:0] cnt_reg;

   always_ff @(posedge sys_clk or negedge rst) begin
      if (!rst) begin
         sync1_reg  <= 1'b0;
         sync2_reg  <= 1'b0;
         stable_reg <= 1'b0;
         cnt_reg    <= '0;
      end else begin
         sync1_reg <= din;
         sync2_reg <= sync1_reg;
         if (sync2_reg == stable_reg) begin
            cnt_reg <= '0;
         end else if (tick) begin
            // Count already at N-1 means this is the N-th tick of the new level.
            if (cnt_reg >= CNT_LAST) begin
               stable_reg <= sync2_reg;
               cnt_reg    <= '0;
            end else begin
               cnt_reg <= cnt_reg + CW'(1);
            end
         end
      end
   end

   assign dout = stable_reg;

endmodule

// File: rtl/semi_cmd_conditioner.sv
// ---------------------------------------------------------------------------
// semi_cmd_conditioner
// Input stage for the semi-auto driving FSM. Debounces four direction buttons
// and four wall-detector bits, turns a single button press into a held
// one-hot command (kept until acknowledged, replaced or timed out) and
// publishes the filtered detector vector with a one-cycle change strobe.
// Ports:
//   sys_clk      in   system clock
//   rst          in   asynchronous reset, active-low
//   power        in   car powered; 0 forces the command path idle
//   btn_raw[3:0] in   raw buttons {left,right,straight,back}, active-high
//   det_raw[3:0] in   raw detector {front,left,right,back}, 1 = obstacle
//   cmd_ack      in   one-cycle pulse: consumer took the command
//   turn_left    out  held command bit
//   turn_right   out  held command bit
//   go_straight  out  held command bit
//   go_back      out  held command bit
//   cmd_valid    out  high while a command is presented
//   detector     out  debounced detector vector
//   det_changed  out  one-cycle pulse after the detector vector changes
// ---------------------------------------------------------------------------
module semi_cmd_conditioner
   import semi_cmd_conditioner_pkg::*;
#(
   parameter int CLK_HZ  = 100_000_000,
   parameter int TICK_HZ = 1000,
   parameter int BTN_DB  = 20,
   parameter int DET_DB  = 5,
   parameter int HOLD_TO = 200
) (
   input  logic       sys_clk,
   input  logic       rst,
   input  logic       power,
   input  logic [3:0] btn_raw,
   input  logic [3:0] det_raw,
   input  logic       cmd_ack,
   output logic       turn_left,
   output logic       turn_right,
   output logic       go_straight,
   output logic       go_back,
   output logic       cmd_valid,
   output logic [3:0] detector,
   output logic       det_changed
);

   localparam int DIV = CLK_HZ / TICK_HZ;
   localparam int PW  = cnt_width(DIV);
   localparam int DBW = cnt_width(max_int(BTN_DB, DET_DB));
   localparam int TOW = cnt_width(HOLD_TO + 1);

   // ---------------- prescaler ----------------
   logic [PW-1:0] pre_cnt_reg;
   logic          tick;

   assign tick = (pre_cnt_reg == PW'(DIV - 1));

   always_ff @(posedge sys_clk or negedge rst) begin
      if (!rst) begin
         pre_cnt_reg <= '0;
      end else if (tick) begin
         pre_cnt_reg <= '0;
      end else begin
         pre_cnt_reg <= pre_cnt_reg + PW'(1);
      end
   end

   // ---------------- debouncers ----------------
   logic [3:0] btn_stable;
   logic [3:0] det_stable;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_db
         debounce_bit #(.N(BTN_DB), .CW(DBW)) u_btn_db (
            .sys_clk (sys_clk),
            .rst     (rst),
            .tick    (tick),
            .din     (btn_raw[gi]),
            .dout    (btn_stable[gi])
         );
         debounce_bit #(.N(DET_DB), .CW(DBW)) u_det_db (
            .sys_clk (sys_clk),
            .rst     (rst),
            .tick    (tick),
            .din     (det_raw[gi]),
            .dout    (det_stable[gi])
         );
      end
   endgenerate

   // ---------------- press edge detect ----------------
   logic [3:0] btn_prev_reg;
   logic [3:0] press;

   assign press = btn_stable & ~btn_prev_reg;

   // ---------------- command FSM ----------------
   cmd_state_t     state_reg,     state_next;
   logic [3:0]     cmd_reg,       cmd_next;
   logic [TOW-1:0] to_cnt_reg,    to_cnt_next;
   logic [3:0]     cmd_out_reg,   cmd_out_next;
   logic           valid_reg,     valid_next;

   always_comb begin
      state_next  = state_reg;
      cmd_next    = cmd_reg;
      to_cnt_next = to_cnt_reg;

      case (state_reg)
         IDLE: begin
            // Simultaneous presses are ambiguous and dropped entirely.
            if (power && is_single(press)) begin
               cmd_next    = press;
               to_cnt_next = '0;
               state_next  = HOLD;
            end
         end
         HOLD: begin
            if (cmd_ack) begin
               state_next = RELEASE;
               cmd_next   = '0;
            end else if (is_single(press) && (press != cmd_reg)) begin
               cmd_next    = press;
               to_cnt_next = '0;
            end else if (tick) begin
               // This tick is the HOLD_TO-th one spent waiting: drop the command.
               if (to_cnt_reg >= TOW'(HOLD_TO - 1)) begin
                  state_next  = IDLE;
                  cmd_next    = '0;
                  to_cnt_next = '0;
               end else begin
                  to_cnt_next = to_cnt_reg + TOW'(1);
               end
            end
         end
         RELEASE: begin
            // Wait for every button to be let go so a held key cannot re-fire.
            if (btn_stable == 4'b0000) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
            cmd_next   = '0;
         end
      endcase

      if (!power) begin
         state_next  = IDLE;
         cmd_next    = '0;
         to_cnt_next = '0;
      end

      // Outputs are registered from the next-state view so they appear the
      // cycle after the decision that produced them.
      cmd_out_next = (state_next == HOLD) ? cmd_next : 4'b0000;
      valid_next   = (state_next == HOLD);
   end

   // ---------------- detector change strobe ----------------
   logic [3:0] det_prev_reg;
   logic       det_changed_reg;

   always_ff @(posedge sys_clk or negedge rst) begin
      if (!rst) begin
         btn_prev_reg    <= '0;
         state_reg       <= IDLE;
         cmd_reg         <= '0;
         to_cnt_reg      <= '0;
         cmd_out_reg     <= '0;
         valid_reg       <= 1'b0;
         det_prev_reg    <= '0;
         det_changed_reg <= 1'b0;
      end else begin
         btn_prev_reg    <= btn_stable;
         state_reg       <= state_next;
         cmd_reg         <= cmd_next;
         to_cnt_reg      <= to_cnt_next;
         cmd_out_reg     <= cmd_out_next;
         valid_reg       <= valid_next;
         det_prev_reg    <= det_stable;
         det_changed_reg <= (det_stable != det_prev_reg);
      end
   end

   assign turn_left   = cmd_out_reg[BTN_L];
   assign turn_right  = cmd_out_reg[BTN_R];
   assign go_straight = cmd_out_reg[BTN_S];
   assign go_back     = cmd_out_reg[BTN_B];
   assign cmd_valid   = valid_reg;
   assign detector    = det_stable;
   assign det_changed = det_changed_reg;

endmodule

// File: tb/tb_semi_cmd_conditioner.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_semi_cmd_conditioner
// Directed bench with small parameters: DIV = 10 cycles per tick, buttons
// need 3 ticks, detector bits 2 ticks, commands time out after 5 ticks.
// Inputs are driven and outputs sampled on the falling clock edge.
// Latencies counted in falling edges after the input change:
//   button -> command : 24..33   (2 sync + 3 ticks + 1 output register)
//   detector update   : 13..22   (2 sync + 2 ticks)
//   timeout           : exactly 49 falling edges after the command appears
// ---------------------------------------------------------------------------
module tb_semi_cmd_conditioner;

   logic       sys_clk = 1'b0;
   logic       rst     = 1'b0;
   logic       power   = 1'b0;
   logic [3:0] btn_raw = 4'b0000;
   logic [3:0] det_raw = 4'b0000;
   logic       cmd_ack = 1'b0;
   logic       turn_left, turn_right, go_straight, go_back;
   logic       cmd_valid, det_changed;
   logic [3:0] detector;
   logic [3:0] cmd_bus;

   int checks = 0;
   int passed = 0;

   always #5 sys_clk = ~sys_clk;

   assign cmd_bus = {turn_left, turn_right, go_straight, go_back};

   semi_cmd_conditioner #(
      .CLK_HZ  (1000),
      .TICK_HZ (100),
      .BTN_DB  (3),
      .DET_DB  (2),
      .HOLD_TO (5)
   ) dut (
      .sys_clk     (sys_clk),
      .rst         (rst),
      .power       (power),
      .btn_raw     (btn_raw),
      .det_raw     (det_raw),
      .cmd_ack     (cmd_ack),
      .turn_left   (turn_left),
      .turn_right  (turn_right),
      .go_straight (go_straight),
      .go_back     (go_back),
      .cmd_valid   (cmd_valid),
      .detector    (detector),
      .det_changed (det_changed)
   );

   task automatic wait_neg(input int n);
      repeat (n) @(negedge sys_clk);
   endtask

   task automatic test_reset;
      logic bad;
      bad = 1'b0;
      rst = 1'b0;
      power = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge sys_clk);
         btn_raw = 4'($urandom);
         det_raw = 4'($urandom);
         cmd_ack = 1'($urandom);
         if (cmd_bus !== 4'b0000 || cmd_valid !== 1'b0 || detector !== 4'b0000 || det_changed !== 1'b0)
            bad = 1'b1;
      end
      checks++;
      if (bad !== 1'b0) $display("FAIL reset_outputs: got nonzero output under reset, required all 0");
      else passed++;
      btn_raw = 4'b0000;
      det_raw = 4'b0000;
      cmd_ack = 1'b0;
      @(negedge sys_clk);
      rst = 1'b1;
      bad = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge sys_clk);
         if (det_changed !== 1'b0 || cmd_valid !== 1'b0 || detector !== 4'b0000) bad = 1'b1;
      end
      checks++;
      if (bad !== 1'b0) $display("FAIL reset_release: got activity after release, required none");
      else passed++;
      $display("test_reset done");
   endtask

   task automatic test_glitch;
      logic bad;
      bad = 1'b0;
      @(negedge sys_clk);
      btn_raw = 4'b1000;
      for (int i = 0; i < 15; i++) begin
         @(negedge sys_clk);
         if (cmd_valid !== 1'b0 || turn_left !== 1'b0) bad = 1'b1;
      end
      btn_raw = 4'b0000;
      for (int i = 0; i < 60; i++) begin
         @(negedge sys_clk);
         if (cmd_valid !== 1'b0 || turn_left !== 1'b0) bad = 1'b1;
      end
      checks++;
      if (bad !== 1'b0) $display("FAIL glitch_ignored: got command from 15-cycle glitch, required none");
      else passed++;
      $display("test_glitch done");
   endtask

   task automatic test_left_press;
      int   n;
      logic bad;
      @(negedge sys_clk);
      btn_raw = 4'b1000;
      n = 0;
      while (cmd_valid !== 1'b1 && n < 80) begin
         @(negedge sys_clk);
         n++;
      end
      checks++;
      if (n < 24 || n > 33) $display("FAIL left_latency: got %0d cycles, required 24..33", n);
      else passed++;
      checks++;
      if (cmd_bus !== 4'b1000) $display("FAIL left_cmd: got %b, required 1000", cmd_bus);
      else passed++;
      cmd_ack = 1'b1;
      @(negedge sys_clk);
      cmd_ack = 1'b0;
      checks++;
      if (cmd_valid !== 1'b0 || cmd_bus !== 4'b0000)
         $display("FAIL ack_clears: got valid=%b cmd=%b, required 0/0000", cmd_valid, cmd_bus);
      else passed++;
      // Straight added while left is still held: must not fire from RELEASE.
      btn_raw = 4'b1010;
      bad = 1'b0;
      for (int i = 0; i < 45; i++) begin
         @(negedge sys_clk);
         if (cmd_valid !== 1'b0) bad = 1'b1;
      end
      checks++;
      if (bad !== 1'b0) $display("FAIL release_blocks: got command while buttons held, required none");
      else passed++;
      btn_raw = 4'b0000;
      wait_neg(40);
      $display("test_left_press done");
   endtask

   task automatic test_timeout;
      int n;
      @(negedge sys_clk);
      btn_raw = 4'b0010;
      n = 0;
      while (cmd_valid !== 1'b1 && n < 80) begin
         @(negedge sys_clk);
         n++;
      end
      checks++;
      if (n < 24 || n > 33 || cmd_bus !== 4'b0010)
         $display("FAIL straight_after_release: got %0d cycles cmd=%b, required 24..33 and 0010", n, cmd_bus);
      else passed++;
      n = 0;
      while (cmd_valid === 1'b1 && n < 120) begin
         @(negedge sys_clk);
         n++;
      end
      checks++;
      if (n != 49) $display("FAIL timeout_drop: got drop after %0d cycles, required 49", n);
      else passed++;
      checks++;
      if (cmd_bus !== 4'b0000) $display("FAIL timeout_cmd: got %b, required 0000", cmd_bus);
      else passed++;
      btn_raw = 4'b0000;
      wait_neg(40);
      $display("test_timeout done");
   endtask

   task automatic test_replace;
      int n;
      @(negedge sys_clk);
      btn_raw = 4'b0010;
      n = 0;
      while (cmd_valid !== 1'b1 && n < 80) begin
         @(negedge sys_clk);
         n++;
      end
      checks++;
      if (cmd_bus !== 4'b0010) $display("FAIL replace_first: got %b, required 0010", cmd_bus);
      else passed++;
      wait_neg(5);
      btn_raw = 4'b0110;
      n = 0;
      while (turn_right !== 1'b1 && n < 80) begin
         @(negedge sys_clk);
         n++;
      end
      checks++;
      if (n < 24 || n > 33) $display("FAIL replace_latency: got %0d cycles, required 24..33", n);
      else passed++;
      checks++;
      if (cmd_bus !== 4'b0100 || cmd_valid !== 1'b1)
         $display("FAIL replace_cmd: got cmd=%b valid=%b, required 0100/1", cmd_bus, cmd_valid);
      else passed++;
      n = 0;
      while (cmd_valid === 1'b1 && n < 120) begin
         @(negedge sys_clk);
         n++;
      end
      checks++;
      if (n != 49) $display("FAIL replace_timeout_restart: got drop after %0d cycles, required 49", n);
      else passed++;
      btn_raw = 4'b0000;
      wait_neg(40);
      $display("test_replace done");
   endtask

   task automatic test_power_and_simultaneous;
      int   n;
      logic bad;
      // Press while unpowered.
      @(negedge sys_clk);
      power = 1'b0;
      btn_raw = 4'b1000;
      bad = 1'b0;
      for (int i = 0; i < 45; i++) begin
         @(negedge sys_clk);
         if (cmd_valid !== 1'b0) bad = 1'b1;
      end
      checks++;
      if (bad !== 1'b0) $display("FAIL power_off_press: got command with power=0, required none");
      else passed++;
      btn_raw = 4'b0000;
      wait_neg(40);
      power = 1'b1;
      // Left and right rising together.
      btn_raw = 4'b1100;
      bad = 1'b0;
      for (int i = 0; i < 45; i++) begin
         @(negedge sys_clk);
         if (cmd_valid !== 1'b0) bad = 1'b1;
      end
      checks++;
      if (bad !== 1'b0) $display("FAIL simultaneous_ignored: got command from two presses, required none");
      else passed++;
      btn_raw = 4'b0000;
      wait_neg(40);
      // Power falls during HOLD.
      btn_raw = 4'b0001;
      n = 0;
      while (cmd_valid !== 1'b1 && n < 80) begin
         @(negedge sys_clk);
         n++;
      end
      checks++;
      if (n < 24 || n > 33 || cmd_bus !== 4'b0001)
         $display("FAIL back_cmd: got %0d cycles cmd=%b, required 24..33 and 0001", n, cmd_bus);
      else passed++;
      power = 1'b0;
      @(negedge sys_clk);
      checks++;
      if (cmd_valid !== 1'b0 || cmd_bus !== 4'b0000)
         $display("FAIL power_drop: got valid=%b cmd=%b, required 0/0000", cmd_valid, cmd_bus);
      else passed++;
      power = 1'b1;
      bad = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge sys_clk);
         if (cmd_valid !== 1'b0) bad = 1'b1;
      end
      checks++;
      if (bad !== 1'b0) $display("FAIL power_restore: got command without new press, required none");
      else passed++;
      btn_raw = 4'b0000;
      wait_neg(40);
      $display("test_power_and_simultaneous done");
   endtask

   task automatic test_detector;
      int n;
      int pulses;
      @(negedge sys_clk);
      power = 1'b0;
      det_raw = 4'b0011;
      n = 0;
      while (detector === 4'b0000 && n < 60) begin
         @(negedge sys_clk);
         n++;
      end
      checks++;
      if (n < 13 || n > 22) $display("FAIL det_latency: got %0d cycles, required 13..22", n);
      else passed++;
      checks++;
      if (detector !== 4'b0011) $display("FAIL det_value: got %b, required 0011", detector);
      else passed++;
      checks++;
      if (det_changed !== 1'b0) $display("FAIL det_pulse_early: got %b, required 0", det_changed);
      else passed++;
      @(negedge sys_clk);
      checks++;
      if (det_changed !== 1'b1) $display("FAIL det_pulse: got %b, required 1", det_changed);
      else passed++;
      pulses = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge sys_clk);
         if (det_changed === 1'b1) pulses++;
      end
      checks++;
      if (pulses != 0) $display("FAIL det_single_pulse: got %0d extra pulses, required 0", pulses);
      else passed++;
      power = 1'b1;
      $display("test_detector done");
   endtask

   task automatic test_reset_mid_hold;
      int   n;
      logic bad;
      @(negedge sys_clk);
      btn_raw = 4'b1000;
      n = 0;
      while (cmd_valid !== 1'b1 && n < 80) begin
         @(negedge sys_clk);
         n++;
      end
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if (cmd_valid !== 1'b0 || cmd_bus !== 4'b0000 || detector !== 4'b0000)
         $display("FAIL async_reset: got valid=%b cmd=%b det=%b, required 0/0000/0000 (hold seen after %0d)",
                  cmd_valid, cmd_bus, detector, n);
      else passed++;
      btn_raw = 4'b0000;
      det_raw = 4'b0000;
      @(negedge sys_clk);
      rst = 1'b1;
      bad = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge sys_clk);
         if (det_changed !== 1'b0 || cmd_valid !== 1'b0) bad = 1'b1;
      end
      checks++;
      if (bad !== 1'b0) $display("FAIL reset_no_pulse: got activity after reset release, required none");
      else passed++;
      $display("test_reset_mid_hold done");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_glitch();
      test_left_press();
      test_timeout();
      test_replace();
      test_power_and_simultaneous();
      test_detector();
      test_reset_mid_hold();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
